// File: rtl/prom_reader_pkg.sv
// -----------------------------------------------------------------------------
// prom_reader_pkg
//
// Shared definitions for the PROM read controller:
//   ADDR_W / DATA_W  - PROM address and data widths
//   prom_rd_state_t  - controller FSM states (PF_ACCESS exists only when
//                      PROM_READER_PREFETCH_EN is defined)
//   max_int()        - elaboration-time helper used to size the delay counter
// -----------------------------------------------------------------------------
package prom_reader_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS    = 2'd1,
    FLOAT     = 2'd2
`ifdef PROM_READER_PREFETCH_EN
    ,
    PF_ACCESS = 2'd3
`endif
  } prom_rd_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/prom_delay_counter.sv
// -----------------------------------------------------------------------------
// prom_delay_counter
//
// Loadable down-counter with a zero flag. The count decrements on every edge
// until it reaches zero and then rests there; a load overrides the decrement.
// One instance times the ACCESS, FLOAT and PF_ACCESS phases of prom_reader.
//
// Ports:
//   clk       in  1  clock, rising edge
//   rst_n     in  1  asynchronous active-low reset (count -> 0)
//   load      in  1  load load_val on this edge
//   load_val  in  W  value to load
//   zero      out 1  count is zero
// -----------------------------------------------------------------------------
module prom_delay_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // NOTE: every variable assigned in always_comb gets a default value first so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/prom_reader.sv
// -----------------------------------------------------------------------------
// prom_reader
//
// Read controller for the asynchronous 16-bit program PROM. Accepts one word
// read at a time over a valid/ready request channel, drives the registered
// PROM address and active-low output enable, waits ACCESS_CYCLES edges for the
// PROM access time, captures the data word and returns it over a valid/ready
// response channel. After each access prom_oen stays high for DF_CYCLES cycles
// so the PROM outputs can float before the next access.
//
// Optional feature macro: PROM_READER_PREFETCH_EN
//   When defined, after a demand access finishes with no request pending the
//   unit prefetches the next sequential word into a one-entry buffer. A request
//   hitting the buffer is answered one edge after acceptance without touching
//   the PROM, and the following word is then prefetched.
//
// Parameters:
//   ACCESS_CYCLES  edges from address/prom_oen low to data capture (>= 1)
//   DF_CYCLES      cycles prom_oen is high between accesses (>= 0)
//
// Ports:
//   clk        in  1   clock, rising edge
//   rst_n      in  1   asynchronous active-low reset
//   req_valid  in  1   read request valid
//   req_ready  out 1   request accepted on an edge where valid && ready
//   req_addr   in  16  word address
//   rsp_valid  out 1   response valid
//   rsp_ready  in  1   response consumed on an edge where valid && ready
//   rsp_data   out 16  data word
//   prom_ain   out 16  PROM address pins (registered)
//   prom_oen   out 1   PROM output enable, active low (registered)
//   prom_dout  in  16  PROM data pins
// -----------------------------------------------------------------------------
module prom_reader
  import prom_reader_pkg::*;
#(
  parameter int ACCESS_CYCLES = 5,
  parameter int DF_CYCLES     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] prom_ain,
  output logic              prom_oen,
  input  logic [DATA_W-1:0] prom_dout
);

  localparam int CNT_W = $clog2(max_int(ACCESS_CYCLES, DF_CYCLES) + 1);

  // Capture happens on the edge where the counter is zero, so loading
  // ACCESS_CYCLES-1 at the accepting edge puts capture at edge ACCESS_CYCLES.
  localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  // The IDLE cycle in which the next request is accepted already has prom_oen
  // high, so it is the last float cycle. FLOAT therefore only has to cover
  // DF_CYCLES-1 cycles, and is skipped entirely for DF_CYCLES <= 1.
  localparam bit               HAS_FLOAT = (DF_CYCLES >= 2);
  localparam logic [CNT_W-1:0] FLT_LOAD  = HAS_FLOAT ? CNT_W'(DF_CYCLES - 2) : '0;

  prom_rd_state_t    state_q,     state_d;
  logic [ADDR_W-1:0] prom_ain_q,  prom_ain_d;
  logic              prom_oen_q,  prom_oen_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_zero;

  logic              req_fire;
  logic              access_done;
  logic              launch;
  logic [ADDR_W-1:0] launch_addr;
  prom_rd_state_t    launch_state;

`ifdef PROM_READER_PREFETCH_EN
  logic              pf_valid_q, pf_valid_d;
  logic [ADDR_W-1:0] pf_addr_q,  pf_addr_d;
  logic [DATA_W-1:0] pf_data_q,  pf_data_d;
  logic              pf_arm_q,   pf_arm_d;   // demand access done, prefetch owed
  logic              hit_q,      hit_d;      // buffer hit accepted last edge
  logic              pf_hit;

  assign pf_hit = pf_valid_q && (req_addr == pf_addr_q);
`endif

  prom_delay_counter #(
    .W (CNT_W)
  ) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  // Gated with rst_n so the request channel reads not-ready throughout reset.
  // In the prefetch build the state is not IDLE while a prefetch is in flight,
  // which keeps requests blocked until it completes.
  assign req_ready = rst_n && (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
  assign req_fire  = req_valid && req_ready;

`ifdef PROM_READER_PREFETCH_EN
  assign access_done = ((state_q == ACCESS) || (state_q == PF_ACCESS)) && cnt_zero;
`else
  assign access_done = (state_q == ACCESS) && cnt_zero;
`endif

  always_comb begin
    state_d      = state_q;
    prom_ain_d   = prom_ain_q;
    prom_oen_d   = prom_oen_q;
    // The response handshake runs independently of the FSM.
    rsp_valid_d  = rsp_valid_q && !rsp_ready;
    rsp_data_d   = rsp_data_q;
    cnt_load     = 1'b0;
    cnt_load_val = ACC_LOAD;
    launch       = 1'b0;
    launch_addr  = req_addr;
    launch_state = ACCESS;
`ifdef PROM_READER_PREFETCH_EN
    pf_valid_d   = pf_valid_q;
    pf_addr_d    = pf_addr_q;
    pf_data_d    = pf_data_q;
    pf_arm_d     = pf_arm_q;
    hit_d        = 1'b0;
    // rsp_data was loaded from the buffer on the accepting edge; the response
    // becomes visible one edge later.
    if (hit_q) begin
      rsp_valid_d = 1'b1;
    end
`endif

    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          launch = 1'b1;
`ifdef PROM_READER_PREFETCH_EN
          pf_valid_d = 1'b0;
          pf_arm_d   = 1'b0;
          if (pf_hit) begin
            rsp_data_d   = pf_data_q;
            hit_d        = 1'b1;
            launch_addr  = req_addr + ADDR_W'(1);
            launch_state = PF_ACCESS;
          end
        end else if (pf_arm_q && !req_valid) begin
          launch       = 1'b1;
          pf_arm_d     = 1'b0;
          launch_addr  = prom_ain_q + ADDR_W'(1);
          launch_state = PF_ACCESS;
`endif
        end
      end
      ACCESS: begin
        if (cnt_zero) begin
          rsp_data_d  = prom_dout;
          rsp_valid_d = 1'b1;
`ifdef PROM_READER_PREFETCH_EN
          pf_arm_d    = 1'b1;
`endif
        end
      end
      FLOAT: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end
      end
`ifdef PROM_READER_PREFETCH_EN
      PF_ACCESS: begin
        if (cnt_zero) begin
          pf_data_d  = prom_dout;
          pf_valid_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // Start of a PROM access, demand or prefetch.
    if (launch) begin
      prom_ain_d   = launch_addr;
      prom_oen_d   = 1'b0;
      cnt_load     = 1'b1;
      cnt_load_val = ACC_LOAD;
      state_d      = launch_state;
`ifdef PROM_READER_PREFETCH_EN
      if (launch_state == PF_ACCESS) begin
        pf_addr_d = launch_addr;
      end
`endif
    end

    // End of an access: release the PROM outputs and enter the float period.
    if (access_done) begin
      prom_oen_d   = 1'b1;
      cnt_load     = 1'b1;
      cnt_load_val = FLT_LOAD;
      if (HAS_FLOAT) begin
        state_d = FLOAT;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // NOTE: all state, including the data holding registers, is reset; there is
  // no memory array here, so the cost is a handful of reset flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prom_ain_q  <= '0;
      prom_oen_q  <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef PROM_READER_PREFETCH_EN
      pf_valid_q  <= 1'b0;
      pf_addr_q   <= '0;
      pf_data_q   <= '0;
      pf_arm_q    <= 1'b0;
      hit_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      prom_ain_q  <= prom_ain_d;
      prom_oen_q  <= prom_oen_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef PROM_READER_PREFETCH_EN
      pf_valid_q  <= pf_valid_d;
      pf_addr_q   <= pf_addr_d;
      pf_data_q   <= pf_data_d;
      pf_arm_q    <= pf_arm_d;
      hit_q       <= hit_d;
`endif
    end
  end

  assign prom_ain  = prom_ain_q;
  assign prom_oen  = prom_oen_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule
